// File: rtl/trace_pkg.sv
// Shared types for the retirement trace monitor: FSM states, record layout and default widths.
package trace_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 4;
    localparam int CNT_W_DEF  = 32;
    localparam int OPC_W      = 4;
    localparam int NUM_OPC    = 1 << OPC_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } monState_t;

    // Field order matches the flat tr_data word, MSB first.
    typedef struct packed {
        logic                  halt;
        logic                  memWe;
        logic                  memRe;
        logic                  wbWe;
        logic [REG_W_DEF-1:0]  wbReg;
        logic [DATA_W_DEF-1:0] wbData;
        logic [DATA_W_DEF-1:0] memAddr;
        logic [DATA_W_DEF-1:0] memWdata;
        logic [DATA_W_DEF-1:0] memRdata;
    } trace_rec_t;
endpackage

// File: rtl/retire_trace_monitor_if.sv
// Tap, status and trace-port bundle between the CPU side (master) and the retirement monitor (slave).
interface retire_trace_monitor_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 32
);
    logic                        run_en, wb_we, mem_re, mem_we, halt;
    logic [REG_W-1:0]            wb_reg;
    logic [DATA_W-1:0]           wb_data, wb_inst, mem_addr, mem_wdata, mem_rdata;
    logic [CNT_W-1:0]            cycle_count, inst_count, drop_count, hist_data;
    logic [1:0]                  state;
    logic                        overflow;
    logic [3:0]                  hist_sel;
    logic                        tr_valid, tr_ready;
    logic [4+REG_W+4*DATA_W-1:0] tr_data;

    modport master (
        output run_en, wb_we, mem_re, mem_we, halt, wb_reg, wb_data, wb_inst,
               mem_addr, mem_wdata, mem_rdata, hist_sel, tr_ready,
        input  cycle_count, inst_count, drop_count, hist_data, state, overflow,
               tr_valid, tr_data
    );

    modport slave (
        input  run_en, wb_we, mem_re, mem_we, halt, wb_reg, wb_data, wb_inst,
               mem_addr, mem_wdata, mem_rdata, hist_sel, tr_ready,
        output cycle_count, inst_count, drop_count, hist_data, state, overflow,
               tr_valid, tr_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a write appears on rdVld the next cycle (no bypass).
// Backpressure: a write at full is refused unless a read in the same cycle frees the head slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wrVld,
    input  logic [WIDTH-1:0] wrDat,
    output logic             full,
    output logic             empty,
    output logic             rdVld,
    input  logic             rdRdy,
    output logic [WIDTH-1:0] rdDat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wrPtr, rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doRd, doWr;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign rdVld = !empty;
    assign rdDat = mem[rdPtr[AW-1:0]];
    assign doRd  = rdVld && rdRdy;
    assign doWr  = wrVld && (!full || doRd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + PTR_ONE;
            if (doRd) rdPtr <= rdPtr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doWr) mem[wrPtr[AW-1:0]] <= wrDat;
    end
endmodule

// File: rtl/retire_trace_monitor.sv
// Retirement monitor: run FSM, saturating cycle/instruction/drop counters, opcode histogram, trace FIFO.
// Latency: counters/state next cycle, trace record valid the cycle after its event; backpressure drops records at full.
module retire_trace_monitor
    import trace_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 4,
    parameter int CNT_W       = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int MAX_CYCLES  = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    retire_trace_monitor_if.slave mon
);
    localparam int               REC_W      = 4 + REG_W + 4 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    monState_t        stateQ, stateD;
    logic             live, active, retire, atLimit, pop, drop;
    logic             fifoFull, fifoEmpty, fifoVld;
    logic [REC_W-1:0] rec, fifoDat;
    logic [CNT_W-1:0] cycleCnt, instCnt, dropCnt, histData;
    logic [CNT_W-1:0] hist [NUM_OPC];
    logic             overflowQ;
    logic [OPC_W-1:0] opc;
    logic             unusedInstBits;

    assign opc            = mon.wb_inst[DATA_W-1 -: OPC_W];
    assign unusedInstBits = &{1'b0, mon.wb_inst[DATA_W-OPC_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) stateQ <= IDLE;
        else     stateQ <= stateD;
    end

    // The IDLE->RUN transition cycle already counts and logs, so a CPU that
    // retires on its first cycle is not missed.
    always_comb begin
        stateD  = stateQ;
        live    = (stateQ == RUN) || (stateQ == IDLE && mon.run_en);
        active  = live && (mon.wb_we || mon.mem_re || mon.mem_we || mon.halt);
        retire  = active && (mon.halt || mon.wb_we || mon.mem_we);
        atLimit = (cycleCnt == LAST_CYCLE);
        if (live) begin
            if (mon.halt)        stateD = HALTED;
            else if (atLimit)    stateD = TIMEOUT;
            else if (mon.run_en) stateD = RUN;
            else                 stateD = IDLE;
        end
    end

    assign rec  = {mon.halt, mon.mem_we, mon.mem_re, mon.wb_we, mon.wb_reg,
                   mon.wb_data, mon.mem_addr, mon.mem_wdata, mon.mem_rdata};
    assign pop  = !fifoEmpty && mon.tr_ready;
    assign drop = active && fifoFull && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCnt  <= '0;
            instCnt   <= '0;
            dropCnt   <= '0;
            overflowQ <= 1'b0;
            histData  <= '0;
            for (int i = 0; i < NUM_OPC; i++) hist[i] <= '0;
        end else begin
            // Count freezes one short of the limit; that cycle trips the timeout instead.
            if (live && !atLimit && cycleCnt != '1) cycleCnt <= cycleCnt + CNT_ONE;
            if (retire && instCnt != '1)            instCnt  <= instCnt + CNT_ONE;
            if (retire && hist[opc] != '1)          hist[opc] <= hist[opc] + CNT_ONE;
            if (drop) begin
                overflowQ <= 1'b1;
                if (dropCnt != '1) dropCnt <= dropCnt + CNT_ONE;
            end
            histData <= hist[mon.hist_sel];
        end
    end

    sync_fifo #(.WIDTH(REC_W), .DEPTH(TRACE_DEPTH)) traceFifo (
        .clk   (clk),
        .rst   (rst),
        .wrVld (active),
        .wrDat (rec),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .rdVld (fifoVld),
        .rdRdy (mon.tr_ready),
        .rdDat (fifoDat)
    );

    assign mon.cycle_count = cycleCnt;
    assign mon.inst_count  = instCnt;
    assign mon.drop_count  = dropCnt;
    assign mon.state       = stateQ;
    assign mon.overflow    = overflowQ;
    assign mon.hist_data   = histData;
    assign mon.tr_valid    = fifoVld;
    assign mon.tr_data     = fifoDat;
endmodule

// File: tb/tb_retire_trace_monitor.sv
// Bench for retire_trace_monitor: directed scenarios plus randomized traffic against a queue-based model.
module tb_retire_trace_monitor;
    import trace_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXC  = 20;
    localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2, S_TIMEOUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    retire_trace_monitor_if #(.DATA_W(16), .REG_W(4), .CNT_W(32)) bus ();

    retire_trace_monitor #(
        .DATA_W(16), .REG_W(4), .CNT_W(32), .TRACE_DEPTH(DEPTH), .MAX_CYCLES(MAXC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain counters and a queue standing in for the FIFO.
    int         mCycle = 0, mInst = 0, mDrop = 0, mState = S_IDLE, mHistData = 0;
    bit         mOverflow = 0;
    int         mHist [16];
    trace_rec_t mQ [$];

    task automatic modelStep();
        trace_rec_t r;
        bit live, act, ret;
        if (rst) begin
            mCycle = 0; mInst = 0; mDrop = 0; mState = S_IDLE; mOverflow = 0; mHistData = 0;
            mQ.delete();
            foreach (mHist[i]) mHist[i] = 0;
            return;
        end
        mHistData = mHist[bus.hist_sel];
        if (bus.tr_ready && mQ.size() != 0) void'(mQ.pop_front());
        live = (mState == S_RUN) || (mState == S_IDLE && bus.run_en);
        act  = live && (bus.wb_we || bus.mem_re || bus.mem_we || bus.halt);
        ret  = act && (bus.halt || bus.wb_we || bus.mem_we);
        if (act) begin
            r = '{halt: bus.halt, memWe: bus.mem_we, memRe: bus.mem_re, wbWe: bus.wb_we,
                  wbReg: bus.wb_reg, wbData: bus.wb_data, memAddr: bus.mem_addr,
                  memWdata: bus.mem_wdata, memRdata: bus.mem_rdata};
            if (mQ.size() < DEPTH) mQ.push_back(r);
            else begin mDrop++; mOverflow = 1; end
        end
        if (ret) begin
            mInst++;
            mHist[bus.wb_inst[15:12]]++;
        end
        if (live) begin
            if (bus.halt) begin
                mState = S_HALTED;
                if (mCycle < MAXC - 1) mCycle++;
            end else if (mCycle == MAXC - 1) begin
                mState = S_TIMEOUT;
            end else begin
                mCycle++;
                mState = bus.run_en ? S_RUN : S_IDLE;
            end
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idleTaps();
        bus.wb_we = 0; bus.mem_re = 0; bus.mem_we = 0; bus.halt = 0;
        bus.wb_reg = '0; bus.wb_data = '0; bus.wb_inst = '0;
        bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_rdata = '0;
    endtask

    task automatic doReset();
        idleTaps();
        bus.run_en = 0; bus.tr_ready = 0; bus.hist_sel = '0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (bus.cycle_count !== 0) begin errors++; $display("FAIL reset_cycle: got %0d want 0", bus.cycle_count); end
        checks++; if (bus.inst_count !== 0) begin errors++; $display("FAIL reset_inst: got %0d want 0", bus.inst_count); end
        checks++; if (bus.drop_count !== 0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        checks++; if (bus.tr_valid !== 1'b0) begin errors++; $display("FAIL reset_tr_valid: got %b want 0", bus.tr_valid); end
        checks++; if (bus.hist_data !== 0) begin errors++; $display("FAIL reset_hist: got %0d want 0", bus.hist_data); end
    endtask

    task automatic test_idle_run();
        doReset();
        bus.run_en = 1;
        repeat (10) tick();
        checks++; if (bus.cycle_count !== 10) begin errors++; $display("FAIL idle_cycle: got %0d want 10", bus.cycle_count); end
        checks++; if (bus.inst_count !== 0) begin errors++; $display("FAIL idle_inst: got %0d want 0", bus.inst_count); end
        checks++; if (bus.tr_valid !== 1'b0) begin errors++; $display("FAIL idle_tr_valid: got %b want 0", bus.tr_valid); end
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL idle_state: got %0d want 1", bus.state); end
    endtask

    task automatic test_add_sw();
        trace_rec_t e;
        doReset();
        bus.run_en = 1;
        tick();
        bus.wb_we = 1; bus.wb_reg = 4'd3; bus.wb_data = 16'h0042; bus.wb_inst = 16'h0312;
        tick();
        idleTaps();
        bus.mem_we = 1; bus.mem_addr = 16'h0010; bus.mem_wdata = 16'h1234; bus.wb_inst = 16'h9010;
        tick();
        idleTaps();
        checks++; if (bus.inst_count !== 2) begin errors++; $display("FAIL addsw_inst: got %0d want 2", bus.inst_count); end
        bus.hist_sel = 4'd0; tick();
        checks++; if (bus.hist_data !== 1) begin errors++; $display("FAIL addsw_hist0: got %0d want 1", bus.hist_data); end
        bus.hist_sel = 4'd9; tick();
        checks++; if (bus.hist_data !== 1) begin errors++; $display("FAIL addsw_hist9: got %0d want 1", bus.hist_data); end
        bus.hist_sel = 4'd1; tick();
        checks++; if (bus.hist_data !== 0) begin errors++; $display("FAIL addsw_hist1: got %0d want 0", bus.hist_data); end
        e = '0; e.wbWe = 1; e.wbReg = 4'd3; e.wbData = 16'h0042;
        checks++; if (bus.tr_valid !== 1'b1 || bus.tr_data !== e) begin errors++; $display("FAIL addsw_rec0: got v=%b %h want v=1 %h", bus.tr_valid, bus.tr_data, e); end
        bus.tr_ready = 1; tick();
        e = '0; e.memWe = 1; e.memAddr = 16'h0010; e.memWdata = 16'h1234;
        checks++; if (bus.tr_valid !== 1'b1 || bus.tr_data !== e) begin errors++; $display("FAIL addsw_rec1: got v=%b %h want v=1 %h", bus.tr_valid, bus.tr_data, e); end
        tick();
        checks++; if (bus.tr_valid !== 1'b0) begin errors++; $display("FAIL addsw_empty: got %b want 0", bus.tr_valid); end
        bus.tr_ready = 0;
    endtask

    task automatic test_overflow();
        trace_rec_t r;
        logic [15:0] expAddr [4];
        int n;
        expAddr[0] = 16'h0001; expAddr[1] = 16'h0002; expAddr[2] = 16'h0003; expAddr[3] = 16'h00AA;
        doReset();
        bus.run_en = 1;
        for (int i = 0; i < 6; i++) begin
            bus.mem_re = 1; bus.mem_addr = 16'(i); bus.mem_rdata = 16'($urandom);
            tick();
        end
        idleTaps();
        checks++; if (bus.drop_count !== 2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", bus.drop_count); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        r = bus.tr_data;
        checks++; if (bus.tr_valid !== 1'b1 || r.memAddr !== 16'h0000) begin errors++; $display("FAIL ovf_head: got v=%b addr=%h want v=1 addr=0000", bus.tr_valid, r.memAddr); end
        // Push into a full FIFO while the head is popped.
        bus.mem_re = 1; bus.mem_addr = 16'h00AA; bus.tr_ready = 1;
        tick();
        idleTaps(); bus.tr_ready = 0;
        checks++; if (bus.drop_count !== 2) begin errors++; $display("FAIL full_pushpop_drop: got %0d want 2", bus.drop_count); end
        bus.tr_ready = 1;
        n = 0;
        for (int k = 0; k < 10 && bus.tr_valid === 1'b1; k++) begin
            r = bus.tr_data;
            if (n < 4) begin
                checks++; if (r.memAddr !== expAddr[n]) begin errors++; $display("FAIL drain_addr%0d: got %h want %h", n, r.memAddr, expAddr[n]); end
            end
            n++;
            tick();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL drain_count: got %0d want 4", n); end
        checks++; if (bus.tr_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", bus.tr_valid); end
        bus.tr_ready = 0;
    endtask

    task automatic test_halt();
        trace_rec_t r;
        doReset();
        bus.run_en = 1;
        repeat (2) tick();
        bus.wb_we = 1; bus.wb_reg = 4'd5; bus.wb_data = 16'h0777; bus.wb_inst = 16'h1000;
        tick();
        idleTaps();
        repeat (3) tick();
        bus.halt = 1; bus.wb_inst = 16'hF000;
        tick();
        idleTaps();
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL halt_state: got %0d want 2", bus.state); end
        checks++; if (bus.cycle_count !== 7) begin errors++; $display("FAIL halt_cycle: got %0d want 7", bus.cycle_count); end
        checks++; if (bus.inst_count !== 2) begin errors++; $display("FAIL halt_inst: got %0d want 2", bus.inst_count); end
        bus.wb_we = 1; bus.mem_we = 1;
        repeat (3) tick();
        idleTaps();
        checks++; if (bus.cycle_count !== 7 || bus.inst_count !== 2) begin errors++; $display("FAIL halt_frozen: got cyc=%0d inst=%0d want cyc=7 inst=2", bus.cycle_count, bus.inst_count); end
        checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL halt_absorb: got %0d want 2", bus.state); end
        bus.tr_ready = 1;
        r = bus.tr_data;
        checks++; if (bus.tr_valid !== 1'b1 || r.wbReg !== 4'd5 || r.halt !== 1'b0) begin errors++; $display("FAIL halt_rec0: got v=%b reg=%0d halt=%b want v=1 reg=5 halt=0", bus.tr_valid, r.wbReg, r.halt); end
        tick();
        r = bus.tr_data;
        checks++; if (bus.tr_valid !== 1'b1 || r.halt !== 1'b1) begin errors++; $display("FAIL halt_rec1: got v=%b halt=%b want v=1 halt=1", bus.tr_valid, r.halt); end
        tick();
        checks++; if (bus.tr_valid !== 1'b0) begin errors++; $display("FAIL halt_drained: got %b want 0", bus.tr_valid); end
        bus.tr_ready = 0;
    endtask

    task automatic test_timeout();
        doReset();
        bus.run_en = 1;
        for (int i = 0; i < 19; i++) begin
            bus.mem_re = (i >= 16); bus.mem_addr = 16'(i);
            tick();
        end
        idleTaps();
        checks++; if (bus.state !== 2'd1 || bus.cycle_count !== 19) begin errors++; $display("FAIL pre_timeout: got st=%0d cyc=%0d want st=1 cyc=19", bus.state, bus.cycle_count); end
        bus.mem_re = 1; bus.mem_addr = 16'h0BEE;
        tick();
        checks++; if (bus.state !== 2'd3 || bus.cycle_count !== 19) begin errors++; $display("FAIL timeout: got st=%0d cyc=%0d want st=3 cyc=19", bus.state, bus.cycle_count); end
        repeat (3) tick();
        idleTaps();
        checks++; if (bus.cycle_count !== 19 || bus.drop_count !== 0) begin errors++; $display("FAIL timeout_frozen: got cyc=%0d drop=%0d want cyc=19 drop=0", bus.cycle_count, bus.drop_count); end
        bus.tr_ready = 1;
        tick();
        checks++; if (bus.tr_valid !== 1'b1) begin errors++; $display("FAIL timeout_drain: got %b want 1", bus.tr_valid); end
        rst = 1;
        tick();
        rst = 0;
        checks++; if (bus.cycle_count !== 0 || bus.inst_count !== 0 || bus.drop_count !== 0) begin errors++; $display("FAIL rst_counts: got %0d/%0d/%0d want 0/0/0", bus.cycle_count, bus.inst_count, bus.drop_count); end
        checks++; if (bus.state !== 2'd0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_state: got st=%0d ovf=%b want st=0 ovf=0", bus.state, bus.overflow); end
        checks++; if (bus.tr_valid !== 1'b0 || bus.hist_data !== 0) begin errors++; $display("FAIL rst_fifo: got v=%b hist=%0d want v=0 hist=0", bus.tr_valid, bus.hist_data); end
        bus.run_en = 0; bus.tr_ready = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            doReset();
            for (int c = 0; c < 26; c++) begin
                bus.run_en    = ($urandom_range(7) != 0);
                bus.wb_we     = ($urandom_range(2) == 0);
                bus.mem_re    = ($urandom_range(3) == 0);
                bus.mem_we    = ($urandom_range(3) == 0);
                bus.halt      = ($urandom_range(24) == 0);
                bus.wb_reg    = 4'($urandom);
                bus.wb_data   = 16'($urandom);
                bus.wb_inst   = 16'($urandom);
                bus.mem_addr  = 16'($urandom);
                bus.mem_wdata = 16'($urandom);
                bus.mem_rdata = 16'($urandom);
                bus.hist_sel  = 4'($urandom);
                bus.tr_ready  = ($urandom_range(2) == 0);
                tick();
                checks++; if (bus.cycle_count !== mCycle) begin errors++; $display("FAIL rnd_cycle it%0d c%0d: got %0d want %0d", it, c, bus.cycle_count, mCycle); end
                checks++; if (bus.inst_count !== mInst) begin errors++; $display("FAIL rnd_inst it%0d c%0d: got %0d want %0d", it, c, bus.inst_count, mInst); end
                checks++; if (bus.drop_count !== mDrop) begin errors++; $display("FAIL rnd_drop it%0d c%0d: got %0d want %0d", it, c, bus.drop_count, mDrop); end
                checks++; if (bus.state !== 2'(mState)) begin errors++; $display("FAIL rnd_state it%0d c%0d: got %0d want %0d", it, c, bus.state, mState); end
                checks++; if (bus.overflow !== mOverflow) begin errors++; $display("FAIL rnd_overflow it%0d c%0d: got %b want %b", it, c, bus.overflow, mOverflow); end
                checks++; if (bus.hist_data !== mHistData) begin errors++; $display("FAIL rnd_hist it%0d c%0d: got %0d want %0d", it, c, bus.hist_data, mHistData); end
                checks++; if (bus.tr_valid !== (mQ.size() != 0)) begin errors++; $display("FAIL rnd_tr_valid it%0d c%0d: got %b want %b", it, c, bus.tr_valid, mQ.size() != 0); end
                if (mQ.size() != 0) begin
                    checks++; if (bus.tr_data !== mQ[0]) begin errors++; $display("FAIL rnd_tr_data it%0d c%0d: got %h want %h", it, c, bus.tr_data, mQ[0]); end
                end
            end
        end
        idleTaps();
    endtask

    initial begin
        test_reset();
        test_idle_run();
        test_add_sw();
        test_overflow();
        test_halt();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
